gamepad_cursor_grid: RTL and testbench

- Parametrised successor to the fixed 10x5 cursor/sprite input timer.
- Samples the 12-bit gamepad vector once per video frame (v_sync rising edge) and moves a cursor on a configurable grid.
- Direction keys auto-repeat after a hold delay.
- A robot sprite walks cell-by-cell toward a latched target under a small FSM.
- Sits between the gamepad reader and the sprite renderer. It drives packed column/row buses for NUM_SPRITES sprites plus LEDG status.

---
 rtl/gamepad_cursor_grid.sv | 241 ++++++++++++++++++++++++
 tb/tb_gamepad_cursor_grid.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamepad_cursor_grid.sv
// gamepad_cursor_grid: samples the gamepad once per video frame, moves an
// auto-repeating cursor on a configurable grid and walks a robot sprite
// toward a latched target. Optional macro GAMEPAD_ROBO_DIAGONAL_EN lets the
// robot step column and row together.
`timescale 1ns/1ps
module gamepad_cursor_grid #(
  parameter int unsigned NUM_COLS      = 10,
  parameter int unsigned NUM_ROWS      = 5,
  parameter int unsigned COL_W         = 4,
  parameter int unsigned ROW_W         = 3,
  parameter int unsigned NUM_SPRITES   = 6,
  parameter logic [NUM_SPRITES*COL_W-1:0] INIT_COLS = {4'd1, 4'd10, 4'd6, 4'd1, 4'd1, 4'd6},
  parameter logic [NUM_SPRITES*ROW_W-1:0] INIT_ROWS = {3'd5, 3'd2, 3'd5, 3'd3, 3'd5, 3'd3},
  parameter int unsigned FIRST_DELAY   = 15,
  parameter int unsigned REPEAT_PERIOD = 5,
  parameter int unsigned STEP_FRAMES   = 4,
  parameter int unsigned WRAP          = 1
) (
  input  logic                         Clock50,
  input  logic                         Reset_n,
  input  logic                         v_sync,
  input  logic [11:0]                  Entradas,
  output logic [NUM_SPRITES*COL_W-1:0] ColunasSprites,
  output logic [NUM_SPRITES*ROW_W-1:0] LinhasSprites,
  output logic [7:0]                   LEDG,
  output logic                         RoboMoving,
  output logic                         RoboArrived
);

  localparam int unsigned HOLD_MAX = FIRST_DELAY + REPEAT_PERIOD - 1;
  localparam int unsigned HOLD_W   = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
  localparam int unsigned STEP_W   = (STEP_FRAMES < 2) ? 1 : $clog2(STEP_FRAMES);
  localparam int unsigned K_UP = 0, K_DOWN = 1, K_LEFT = 2, K_RIGHT = 3, K_A = 4, K_START = 10;

  localparam logic [COL_W-1:0] INIT_CUR_COL = INIT_COLS[COL_W-1:0];
  localparam logic [ROW_W-1:0] INIT_CUR_ROW = INIT_ROWS[ROW_W-1:0];
  localparam logic [COL_W-1:0] INIT_ROB_COL = INIT_COLS[2*COL_W-1:COL_W];
  localparam logic [ROW_W-1:0] INIT_ROB_ROW = INIT_ROWS[2*ROW_W-1:ROW_W];
  localparam logic [7:0]       LEDG_INIT    = 8'(1) << 3'(INIT_CUR_COL - COL_W'(1));

  typedef enum logic [1:0] {IDLE, MOVE, ARRIVE} state_t;

  // Cursor axis step with wrap or clamp at the grid edges.
  function automatic logic [COL_W-1:0] col_step(input logic [COL_W-1:0] c, input logic inc);
    if (inc) begin
      if (c >= COL_W'(NUM_COLS)) return (WRAP != 0) ? COL_W'(1) : COL_W'(NUM_COLS);
      return c + COL_W'(1);
    end
    if (c <= COL_W'(1)) return (WRAP != 0) ? COL_W'(NUM_COLS) : COL_W'(1);
    return c - COL_W'(1);
  endfunction

  function automatic logic [ROW_W-1:0] row_step(input logic [ROW_W-1:0] r, input logic inc);
    if (inc) begin
      if (r >= ROW_W'(NUM_ROWS)) return (WRAP != 0) ? ROW_W'(1) : ROW_W'(NUM_ROWS);
      return r + ROW_W'(1);
    end
    if (r <= ROW_W'(1)) return (WRAP != 0) ? ROW_W'(NUM_ROWS) : ROW_W'(1);
    return r - ROW_W'(1);
  endfunction

  // Robot axis step: one cell toward the target, never wrapping.
  function automatic logic [COL_W-1:0] col_toward(input logic [COL_W-1:0] c, input logic [COL_W-1:0] t);
    if (c < t) return c + COL_W'(1);
    if (c > t) return c - COL_W'(1);
    return c;
  endfunction

  function automatic logic [ROW_W-1:0] row_toward(input logic [ROW_W-1:0] r, input logic [ROW_W-1:0] t);
    if (r < t) return r + ROW_W'(1);
    if (r > t) return r - ROW_W'(1);
    return r;
  endfunction

  logic                   vs_meta, vs_sync, vs_prev, tick;
  logic                   v_both, h_both, a_rise;
  logic [3:0]             fire;
  logic [3:0][HOLD_W-1:0] hold_q, hold_d;
  logic [COL_W-1:0]       cur_col_q, cur_col_d, rob_col_q, rob_col_d, tgt_col_q, tgt_col_d;
  logic [ROW_W-1:0]       cur_row_q, cur_row_d, rob_row_q, rob_row_d, tgt_row_q, tgt_row_d;
  logic [COL_W-1:0]       eff_col, nxt_col;
  logic [ROW_W-1:0]       eff_row, nxt_row;
  logic [STEP_W-1:0]      step_q, step_d;
  logic                   start_prev_q, start_prev_d, a_prev_q, a_prev_d;
  state_t                 state_q, state_d;
  logic                   unused_keys;

  assign unused_keys = ^{Entradas[11], Entradas[9:5]};
  assign tick        = vs_sync & ~vs_prev;
  assign v_both      = Entradas[K_UP] & Entradas[K_DOWN];
  assign h_both      = Entradas[K_LEFT] & Entradas[K_RIGHT];

  // Two-flop synchroniser plus edge history for the frame tick.
  always_ff @(posedge Clock50 or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= v_sync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  // Per-key hold counters, Start edge and cursor movement on each tick.
  always_comb begin
    hold_d       = hold_q;
    cur_col_d    = cur_col_q;
    cur_row_d    = cur_row_q;
    start_prev_d = start_prev_q;
    fire         = '0;
    if (tick) begin
      start_prev_d = Entradas[K_START];
      for (int k = 0; k < 4; k++) begin
        if (!Entradas[k] || ((k < 2) ? v_both : h_both)) begin
          hold_d[k] = '0;
        end else begin
          fire[k]   = (hold_q[k] == '0) || (hold_q[k] == HOLD_W'(FIRST_DELAY));
          hold_d[k] = (hold_q[k] == HOLD_W'(HOLD_MAX)) ? HOLD_W'(FIRST_DELAY)
                                                       : hold_q[k] + HOLD_W'(1);
        end
      end
      if (Entradas[K_START] && !start_prev_q) begin
        cur_col_d = INIT_CUR_COL;
        cur_row_d = INIT_CUR_ROW;
      end else begin
        if (fire[K_UP])    cur_row_d = row_step(cur_row_q, 1'b0);
        if (fire[K_DOWN])  cur_row_d = row_step(cur_row_q, 1'b1);
        if (fire[K_LEFT])  cur_col_d = col_step(cur_col_q, 1'b0);
        if (fire[K_RIGHT]) cur_col_d = col_step(cur_col_q, 1'b1);
      end
    end
  end

  // Robot FSM next state, target latch and stepping toward the target.
  always_comb begin
    state_d   = state_q;
    tgt_col_d = tgt_col_q;
    tgt_row_d = tgt_row_q;
    rob_col_d = rob_col_q;
    rob_row_d = rob_row_q;
    step_d    = step_q;
    a_prev_d  = a_prev_q;
    a_rise    = tick && Entradas[K_A] && !a_prev_q;
    eff_col   = a_rise ? cur_col_q : tgt_col_q;
    eff_row   = a_rise ? cur_row_q : tgt_row_q;
    nxt_col   = col_toward(rob_col_q, eff_col);
`ifdef GAMEPAD_ROBO_DIAGONAL_EN
    nxt_row   = row_toward(rob_row_q, eff_row);
`else
    nxt_row   = (rob_col_q == eff_col) ? row_toward(rob_row_q, eff_row) : rob_row_q;
`endif
    if (tick) a_prev_d = Entradas[K_A];
    if (a_rise) begin
      tgt_col_d = cur_col_q;
      tgt_row_d = cur_row_q;
    end
    case (state_q)
      IDLE: begin
        if (a_rise) begin
          if (cur_col_q == rob_col_q && cur_row_q == rob_row_q) begin
            state_d = ARRIVE;
          end else begin
            state_d = MOVE;
            step_d  = '0;
          end
        end
      end
      MOVE: begin
        if (tick) begin
          if (step_q == STEP_W'(STEP_FRAMES - 1)) begin
            step_d    = '0;
            rob_col_d = nxt_col;
            rob_row_d = nxt_row;
            if (nxt_col == eff_col && nxt_row == eff_row) state_d = ARRIVE;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      ARRIVE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clock50 or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Cursor, robot and counter registers.
  always_ff @(posedge Clock50 or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_q       <= '0;
      cur_col_q    <= INIT_CUR_COL;
      cur_row_q    <= INIT_CUR_ROW;
      rob_col_q    <= INIT_ROB_COL;
      rob_row_q    <= INIT_ROB_ROW;
      tgt_col_q    <= INIT_ROB_COL;
      tgt_row_q    <= INIT_ROB_ROW;
      step_q       <= '0;
      start_prev_q <= 1'b0;
      a_prev_q     <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      cur_col_q    <= cur_col_d;
      cur_row_q    <= cur_row_d;
      rob_col_q    <= rob_col_d;
      rob_row_q    <= rob_row_d;
      tgt_col_q    <= tgt_col_d;
      tgt_row_q    <= tgt_row_d;
      step_q       <= step_d;
      start_prev_q <= start_prev_d;
      a_prev_q     <= a_prev_d;
    end
  end

  // Registered sprite buses, LED column indicator and robot status.
  always_ff @(posedge Clock50 or negedge Reset_n) begin
    if (!Reset_n) begin
      ColunasSprites <= INIT_COLS;
      LinhasSprites  <= INIT_ROWS;
      LEDG           <= LEDG_INIT;
      RoboMoving     <= 1'b0;
      RoboArrived    <= 1'b0;
    end else begin
      ColunasSprites                  <= INIT_COLS;
      ColunasSprites[COL_W-1:0]       <= cur_col_q;
      ColunasSprites[2*COL_W-1:COL_W] <= rob_col_q;
      LinhasSprites                   <= INIT_ROWS;
      LinhasSprites[ROW_W-1:0]        <= cur_row_q;
      LinhasSprites[2*ROW_W-1:ROW_W]  <= rob_row_q;
      LEDG                            <= 8'(1) << 3'(cur_col_q - COL_W'(1));
      RoboMoving                      <= (state_d == MOVE);
      RoboArrived                     <= (state_d == ARRIVE);
    end
  end

endmodule

// File: tb/tb_gamepad_cursor_grid.sv
// Scoreboard bench for gamepad_cursor_grid: stimulus runs a behavioural
// model per frame and queues the expected outputs; a monitor checks them.
`timescale 1ns/1ps
module tb_gamepad_cursor_grid;

  localparam int NC = 10, NR = 5, FD = 15, RP = 5, SF = 4, WRAPV = 1;
  localparam logic [11:0] UP = 12'h001, DOWN = 12'h002, LEFT = 12'h004,
                          RIGHT = 12'h008, KA = 12'h010, START = 12'h400;

  logic        Clock50 = 1'b0;
  logic        Reset_n = 1'b0;
  logic        v_sync  = 1'b0;
  logic [11:0] Entradas = '0;
  logic [23:0] ColunasSprites;
  logic [17:0] LinhasSprites;
  logic [7:0]  LEDG;
  logic        RoboMoving, RoboArrived;

  gamepad_cursor_grid dut (
    .Clock50(Clock50), .Reset_n(Reset_n), .v_sync(v_sync), .Entradas(Entradas),
    .ColunasSprites(ColunasSprites), .LinhasSprites(LinhasSprites), .LEDG(LEDG),
    .RoboMoving(RoboMoving), .RoboArrived(RoboArrived)
  );

  always #10 Clock50 = ~Clock50;

  typedef struct {
    logic [23:0] cols;
    logic [17:0] rows;
    logic [7:0]  ledg;
    logic        moving;
    int          arrivals;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int init_col[6] = '{6, 1, 1, 6, 10, 1};
  int init_row[6] = '{3, 5, 3, 5, 2, 5};

  // Reference model state: cursor, robot, target, per-key hold lengths.
  int m_col, m_row, m_rc, m_rr, m_tc, m_tr, m_steps;
  int m_hold[4];
  bit m_sprev, m_aprev, m_moving;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_cols(input int c0, input int c1);
    logic [23:0] v;
    for (int s = 0; s < 6; s++) v[s*4 +: 4] = 4'(init_col[s]);
    v[3:0] = 4'(c0);
    v[7:4] = 4'(c1);
    return v;
  endfunction

  function automatic logic [17:0] exp_rows(input int r0, input int r1);
    logic [17:0] v;
    for (int s = 0; s < 6; s++) v[s*3 +: 3] = 3'(init_row[s]);
    v[2:0] = 3'(r0);
    v[5:3] = 3'(r1);
    return v;
  endfunction

  function automatic int mv(input int v, input int d, input int mx);
    int n = v + d;
    if (n < 1)  n = (WRAPV != 0) ? mx : 1;
    if (n > mx) n = (WRAPV != 0) ? 1 : mx;
    return n;
  endfunction

  function automatic int sgn(input int x);
    return (x > 0) ? 1 : ((x < 0) ? -1 : 0);
  endfunction

  // A key that has been held for h earlier ticks moves on this tick?
  function automatic bit repeats(input int h);
    return (h == 0) || (h >= FD && ((h - FD) % RP) == 0);
  endfunction

  task automatic model_reset();
    m_col = init_col[0]; m_row = init_row[0];
    m_rc = init_col[1];  m_rr = init_row[1];
    m_tc = m_rc; m_tr = m_rr; m_steps = 0;
    for (int k = 0; k < 4; k++) m_hold[k] = 0;
    m_sprev = 0; m_aprev = 0; m_moving = 0;
  endtask

  task automatic model_tick(input logic [11:0] e);
    int  oc, orow, arr;
    bit  ar, sr, pressed;
    bit  f[4];
    exp_t x;
    oc = m_col; orow = m_row; arr = 0;
    ar = e[4] && !m_aprev;
    sr = e[10] && !m_sprev;
    m_aprev = e[4]; m_sprev = e[10];
    for (int k = 0; k < 4; k++) begin
      pressed = e[k] && !((k < 2) ? (e[0] && e[1]) : (e[2] && e[3]));
      f[k] = pressed && repeats(m_hold[k]);
      m_hold[k] = pressed ? m_hold[k] + 1 : 0;
    end
    if (sr) begin
      m_col = init_col[0]; m_row = init_row[0];
    end else begin
      if (f[0]) m_row = mv(m_row, -1, NR);
      if (f[1]) m_row = mv(m_row, 1, NR);
      if (f[2]) m_col = mv(m_col, -1, NC);
      if (f[3]) m_col = mv(m_col, 1, NC);
    end
    if (ar) begin m_tc = oc; m_tr = orow; end
    if (!m_moving) begin
      if (ar) begin
        if (m_tc == m_rc && m_tr == m_rr) arr = 1;
        else begin m_moving = 1; m_steps = 0; end
      end
    end else begin
      m_steps++;
      if (m_steps == SF) begin
        m_steps = 0;
`ifdef GAMEPAD_ROBO_DIAGONAL_EN
        m_rc += sgn(m_tc - m_rc);
        m_rr += sgn(m_tr - m_rr);
`else
        if (m_rc != m_tc) m_rc += sgn(m_tc - m_rc);
        else              m_rr += sgn(m_tr - m_rr);
`endif
        if (m_rc == m_tc && m_rr == m_tr) begin m_moving = 0; arr = 1; end
      end
    end
    x.cols     = exp_cols(m_col, m_rc);
    x.rows     = exp_rows(m_row, m_rr);
    x.ledg     = 8'(1 << ((m_col - 1) % 8));
    x.moving   = m_moving;
    x.arrivals = arr;
    q.push_back(x);
  endtask

  // One video frame: queue the model's prediction, then pulse v_sync.
  task automatic frame(input logic [11:0] e);
    model_tick(e);
    @(negedge Clock50);
    Entradas = e;
    v_sync   = 1'b1;
    repeat (6) @(negedge Clock50);
    v_sync   = 1'b0;
    repeat (6) @(negedge Clock50);
  endtask

  // Monitor: each v_sync pulse pops one prediction and checks the DUT.
  initial begin : monitor
    exp_t e;
    int   arr;
    bit   have;
    forever begin
      @(posedge v_sync);
      arr  = 0;
      have = (q.size() != 0);
      if (have) e = q.pop_front();
      else begin
        n_vec++; n_bad++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
      end
      for (int i = 0; i < 6; i++) begin
        @(negedge Clock50);
        if (RoboArrived === 1'b1) arr++;
        if (i == 3 && have) begin
          chk("cols_bus", 32'(ColunasSprites), 32'(e.cols));
          chk("rows_bus", 32'(LinhasSprites), 32'(e.rows));
          chk("ledg", 32'(LEDG), 32'(e.ledg));
          chk("robo_moving", 32'(RoboMoving), 32'(e.moving));
        end
      end
      if (have) chk("robo_arrived_pulses", 32'(arr), 32'(e.arrivals));
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [11:0] e, n;
    model_reset();
    #25;
    chk("reset_cols", 32'(ColunasSprites), 32'(exp_cols(6, 1)));
    chk("reset_rows", 32'(LinhasSprites), 32'(exp_rows(3, 5)));
    chk("reset_ledg", 32'(LEDG), 32'h20);
    chk("reset_moving", 32'(RoboMoving), 32'd0);
    chk("reset_arrived", 32'(RoboArrived), 32'd0);
    @(negedge Clock50);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clock50);

    frame('0);
    for (int i = 0; i < 30; i++) frame(RIGHT);
    chk("right_hold_col", 32'(ColunasSprites[3:0]), 32'd10);
    frame('0);
    frame(RIGHT);
    chk("right_wrap_col", 32'(ColunasSprites[3:0]), 32'd1);
    frame(START);
    frame('0);
    for (int i = 0; i < 3; i++) frame(UP | DOWN);
    chk("up_down_row", 32'(LinhasSprites[2:0]), 32'd3);
    frame('0);
    frame(UP | LEFT);
    chk("diag_col", 32'(ColunasSprites[3:0]), 32'd5);
    chk("diag_row", 32'(LinhasSprites[2:0]), 32'd2);
    chk("diag_ledg", 32'(LEDG), 32'h10);
    frame(START);
    frame('0);

    frame(KA);
    for (int i = 0; i < 28; i++) frame('0);
    chk("robot_col", 32'(ColunasSprites[7:4]), 32'd6);
    chk("robot_row", 32'(LinhasSprites[5:3]), 32'd3);
    frame(KA);
    frame('0);

    frame(LEFT); frame('0); frame(LEFT); frame('0);
    frame(KA);
    for (int i = 0; i < 6; i++) frame('0);
    chk("mid_move_moving", 32'(RoboMoving), 32'd1);
    Reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_robot_col", 32'(ColunasSprites[7:4]), 32'd1);
    chk("rst_robot_row", 32'(LinhasSprites[5:3]), 32'd5);
    chk("rst_moving", 32'(RoboMoving), 32'd0);
    chk("rst_arrived", 32'(RoboArrived), 32'd0);
    repeat (2) @(negedge Clock50);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clock50);
    frame('0);

    frame(UP); frame('0); frame(UP); frame('0);
    for (int i = 0; i < 3; i++) begin frame(RIGHT); frame('0); end
    chk("pre_start_col", 32'(ColunasSprites[3:0]), 32'd9);
    chk("pre_start_row", 32'(LinhasSprites[2:0]), 32'd1);
    frame(START);
    chk("start_col", 32'(ColunasSprites[3:0]), 32'd6);
    chk("start_row", 32'(LinhasSprites[2:0]), 32'd3);
    frame('0);

    e = '0;
    for (int f = 0; f < 400; f++) begin
      n = 12'($urandom);
      if ($urandom_range(0, 9) < 8) n[3:0] = e[3:0];
      n[4]  = ($urandom_range(0, 5) == 0);
      n[10] = ($urandom_range(0, 15) == 0);
      e = n;
      frame(e);
    end

    repeat (5) @(negedge Clock50);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
